// File: rtl/burst_ram_responder.sv
// -----------------------------------------------------------------------------
// burst_ram_responder
//
// Block-RAM stand-in for the PSRAM controller on the 64-bit 'br_' burst
// command interface. Lets RAMIO and the cache run on boards without PSRAM and
// in simulation.
//
// What it does:
//   - Accepts read and write burst commands of BURST_LEN 64-bit beats.
//   - Stores write data, with a per-byte mask on every beat.
//   - Returns read bursts with a fixed latency of READ_LATENCY cycles.
//   - Flags an initiator that issues a command while the responder is busy.
//
// Ports:
//   clk               clock
//   rst_n             asynchronous active-low reset
//   br_cmd            0: read, 1: write (qualified by br_cmd_en)
//   br_cmd_en         command valid this cycle
//   br_addr           first 64-bit word of the burst
//   br_wr_data        write beat (beat 0 alongside the command, then one per cycle)
//   br_data_mask      per-beat byte mask, bit=1 leaves that byte unwritten
//   br_rd_data        read beat, forced to zero when br_rd_data_valid is low
//   br_rd_data_valid  br_rd_data holds a beat
//   init_done         responder has finished its start-up delay
//   busy              a command presented now would not be accepted
//   protocol_error    sticky flag: command seen while busy
//
// Reset does not touch the memory array. A reset in the middle of a burst
// drops any pending read beats. Write beats already stored are kept.
// -----------------------------------------------------------------------------
module burst_ram_responder #(
  parameter int DEPTH_BITWIDTH = 10,
  parameter int BURST_LEN      = 4,
  parameter int READ_LATENCY   = 6,
  parameter int WRITE_RECOVERY = 2,
  parameter int INIT_CYCLES    = 16,
  parameter     INIT_FILE      = ""
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      br_cmd,
  input  logic                      br_cmd_en,
  input  logic [DEPTH_BITWIDTH-1:0] br_addr,
  input  logic [63:0]               br_wr_data,
  input  logic [7:0]                br_data_mask,
  output logic [63:0]               br_rd_data,
  output logic                      br_rd_data_valid,
  output logic                      init_done,
  output logic                      busy,
  output logic                      protocol_error
);

  localparam int DEPTH  = 1 << DEPTH_BITWIDTH;
  localparam int BEAT_W = (BURST_LEN > 2) ? $clog2(BURST_LEN) : 1;

  localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(BURST_LEN - 1);
  localparam logic [31:0]       INIT_LAST  = 32'(INIT_CYCLES - 1);
  // The BRAM output register adds one cycle, so RD_WAIT lasts READ_LATENCY-1
  // cycles. The beat-0 address is issued in the last of those cycles.
  localparam logic [31:0]       WAIT_LAST  = 32'(READ_LATENCY - 2);
  localparam logic [31:0]       RECOV_LAST = 32'(WRITE_RECOVERY - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_RD_WAIT,
    S_RD_BURST,
    S_WR_BURST,
    S_WR_RECOVER
  } state_t;

  state_t                      state_q, state_d;
  logic [31:0]                 cnt_q, cnt_d;
  logic [BEAT_W-1:0]           beat_q, beat_d;
  logic [DEPTH_BITWIDTH-1:0]   addr_q, addr_d;
  logic                        perr_q, perr_d;

  // Memory port controls, decoded from the FSM each cycle.
  logic                        wr_en;
  logic [DEPTH_BITWIDTH-1:0]   wr_addr;
  logic [63:0]                 wr_data;
  logic [7:0]                  wr_mask;
  logic                        rd_issue;
  logic [DEPTH_BITWIDTH-1:0]   rd_addr;

  // Registered BRAM read stage.
  logic [63:0]                 rd_q_p0;
  logic                        vld_p0;

  logic [63:0] mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Control state: FSM, counters and sticky error flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      beat_q  <= '0;
      perr_q  <= 1'b0;
      vld_p0  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      perr_q  <= perr_d;
      vld_p0  <= rd_issue;
    end
  end

  // The base address is datapath: it is always reloaded on accept before use.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    beat_d   = beat_q;
    addr_d   = addr_q;
    // A command presented in any state other than IDLE is ignored and recorded.
    perr_d   = perr_q | (br_cmd_en && (state_q != S_IDLE));
    wr_en    = 1'b0;
    wr_addr  = addr_q + DEPTH_BITWIDTH'(beat_q);
    wr_data  = br_wr_data;
    wr_mask  = br_data_mask;
    rd_issue = 1'b0;
    rd_addr  = addr_q;

    case (state_q)
      S_INIT: begin
        if (cnt_q == INIT_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      S_IDLE: begin
        if (br_cmd_en) begin
          addr_d = br_addr;
          cnt_d  = '0;
          if (br_cmd) begin
            // Beat 0 travels with the command and is stored at this edge.
            wr_en   = 1'b1;
            wr_addr = br_addr;
            beat_d  = BEAT_W'(1);
            state_d = S_WR_BURST;
          end else begin
            beat_d  = '0;
            state_d = S_RD_WAIT;
          end
        end
      end

      S_RD_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          rd_issue = 1'b1;
          rd_addr  = addr_q;
          beat_d   = '0;
          state_d  = S_RD_BURST;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      S_RD_BURST: begin
        // beat_q is the beat leaving the BRAM register now. Fetch the next one.
        if (beat_q != BEAT_LAST) begin
          rd_issue = 1'b1;
          rd_addr  = addr_q + DEPTH_BITWIDTH'(beat_q) + DEPTH_BITWIDTH'(1);
          beat_d   = beat_q + BEAT_W'(1);
        end else begin
          beat_d  = '0;
          state_d = S_IDLE;
        end
      end

      S_WR_BURST: begin
        wr_en = 1'b1;
        if (beat_q == BEAT_LAST) begin
          beat_d = '0;
          cnt_d  = '0;
          if (WRITE_RECOVERY == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_WR_RECOVER;
          end
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end

      S_WR_RECOVER: begin
        if (cnt_q == RECOV_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      default: begin
        state_d = S_INIT;
        cnt_d   = '0;
        beat_d  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage p0: BRAM write with byte mask, registered BRAM read
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 8; i++) begin
        if (!wr_mask[i]) begin
          mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
    rd_q_p0 <= mem[rd_addr];
  end

  // ---------------------------------------------------------------------------
  // Output: zero the bus between beats
  // ---------------------------------------------------------------------------
  assign br_rd_data       = vld_p0 ? rd_q_p0 : 64'd0;
  assign br_rd_data_valid = vld_p0;
  assign init_done        = (state_q != S_INIT);
  assign busy             = (state_q != S_IDLE);
  assign protocol_error   = perr_q;

endmodule
